// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT address sequencer.
// Holds the state encoding, width derivations and the index arithmetic helpers.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } fft_state_e;

    function automatic int calc_log2n(input int n);
        return $clog2(n);
    endfunction

    // The stage counter needs at least one bit even for the smallest transform.
    function automatic int calc_stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    localparam int DEF_N       = 16;
    localparam int DEF_LOG2N   = calc_log2n(DEF_N);
    localparam int DEF_STAGE_W = calc_stage_w(DEF_LOG2N);

    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = value[width-1-i];
            end
        end
        return r;
    endfunction

    // Opens a zero at bit position s of k: the top operand of butterfly k in stage s.
    function automatic logic [31:0] insert_zero(input logic [31:0] k, input int s);
        logic [31:0] lo_mask;
        lo_mask = (32'd1 << s) - 32'd1;
        return ((k >> s) << (s + 1)) | (k & lo_mask);
    endfunction

endpackage

// File: rtl/fft_bfly_index.sv
// Combinational map from butterfly counter k and stage s to the operand pair
// and the twiddle ROM index for an in-place radix-2 DIT FFT.
module fft_bfly_index
    import fft_pkg::*;
#(
    parameter int LOG2N   = DEF_LOG2N,
    parameter int STAGE_W = DEF_STAGE_W
) (
    input  logic [LOG2N-2:0]   k_i,
    input  logic [STAGE_W-1:0] s_i,
    output logic [LOG2N-1:0]   addr_a_o,
    output logic [LOG2N-1:0]   addr_b_o,
    output logic [LOG2N-2:0]   tw_idx_o
);

    logic [31:0] a_full;
    logic [31:0] b_full;
    logic [31:0] lo_full;
    logic [31:0] tw_full;
    logic        unused_bits;

    always_comb begin
        a_full  = insert_zero(32'(k_i), int'(s_i));
        b_full  = a_full | (32'd1 << s_i);
        lo_full = 32'(k_i) & ((32'd1 << s_i) - 32'd1);
        // Twiddle step doubles resolution each stage: W_N^(lo * N/2^(s+1)).
        tw_full = lo_full << (LOG2N - 1 - int'(s_i));
    end

    assign addr_a_o = a_full[LOG2N-1:0];
    assign addr_b_o = b_full[LOG2N-1:0];
    assign tw_idx_o = tw_full[LOG2N-2:0];

    assign unused_bits = ^{a_full[31:LOG2N], b_full[31:LOG2N], lo_full, tw_full[31:LOG2N-1]};

endmodule

// File: rtl/fft_addr_gen.sv
// Address sequencer for an in-place radix-2 DIT FFT: optional bit-reversed load
// stream, then per-stage butterfly operand pairs, with a drain gap between stages.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int  N         = 16,
    parameter int  LOG2N     = $clog2(N),
    parameter int  STAGE_GAP = 2,
    localparam int STAGE_W   = calc_stage_w(LOG2N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               bitrev_en,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               phase,
    output logic [LOG2N-1:0]   addr_a,
    output logic [LOG2N-1:0]   addr_b,
    output logic [LOG2N-2:0]   tw_idx,
    output logic [STAGE_W-1:0] stage,
    output logic               last,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    // Handshake: an item transfers on a rising clk edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 every output
    // holds, and out_valid never drops before its item is accepted.

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] LOAD = ST_LOAD;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] GAP  = ST_GAP;

    localparam logic [LOG2N-1:0]   K_LOAD_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0]   K_RUN_LAST  = LOG2N'(N / 2 - 1);
    localparam logic [STAGE_W-1:0] S_LAST      = STAGE_W'(LOG2N - 1);
    localparam logic [3:0]         GAP_LAST    = 4'(STAGE_GAP - 1);
    localparam bit                 HAS_GAP     = (STAGE_GAP != 0);

    logic [1:0]         state_q, state_d;
    logic [LOG2N-1:0]   k_q, k_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [3:0]         gap_q, gap_d;

    logic               valid_q, valid_d;
    logic               phase_q, phase_d;
    logic [LOG2N-1:0]   addr_a_q, addr_a_d;
    logic [LOG2N-1:0]   addr_b_q, addr_b_d;
    logic [LOG2N-2:0]   tw_q, tw_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer;
    logic [31:0]        rev_full;
    logic [LOG2N-1:0]   bf_a, bf_b;
    logic [LOG2N-2:0]   bf_tw;
    logic               unused_rev;

    assign xfer = valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = bitrev_en ? LOAD : RUN;
                    k_d     = '0;
                    s_d     = '0;
                    valid_d = 1'b1;
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (k_q == K_LOAD_LAST) begin
                        k_d = '0;
                        if (HAS_GAP) begin
                            state_d = GAP;
                            gap_d   = '0;
                            valid_d = 1'b0;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        k_d = k_q + LOG2N'(1);
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    if (k_q == K_RUN_LAST) begin
                        k_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = IDLE;
                            s_d     = '0;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            s_d = s_q + STAGE_W'(1);
                            if (HAS_GAP) begin
                                state_d = GAP;
                                gap_d   = '0;
                                valid_d = 1'b0;
                            end
                        end
                    end else begin
                        k_d = k_q + LOG2N'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = RUN;
                    gap_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    fft_bfly_index #(
        .LOG2N   (LOG2N),
        .STAGE_W (STAGE_W)
    ) u_bfly_index (
        .k_i      (k_d[LOG2N-2:0]),
        .s_i      (s_d),
        .addr_a_o (bf_a),
        .addr_b_o (bf_b),
        .tw_idx_o (bf_tw)
    );

    // Item fields are built from the next-state counters so they register alongside out_valid.
    always_comb begin
        rev_full = bit_reverse(32'(k_d), LOG2N);
        phase_d  = 1'b0;
        addr_a_d = '0;
        addr_b_d = '0;
        tw_d     = '0;
        stage_d  = '0;
        last_d   = 1'b0;
        busy_d   = (state_d != IDLE);
        if (valid_d) begin
            if (state_d == LOAD) begin
                addr_a_d = rev_full[LOG2N-1:0];
                last_d   = (k_d == K_LOAD_LAST);
            end else begin
                phase_d  = 1'b1;
                addr_a_d = bf_a;
                addr_b_d = bf_b;
                tw_d     = bf_tw;
                stage_d  = s_d;
                last_d   = (k_d == K_RUN_LAST);
            end
        end
    end

    assign unused_rev = ^rev_full[31:LOG2N];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            s_q      <= '0;
            gap_q    <= '0;
            valid_q  <= 1'b0;
            phase_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            s_q      <= s_d;
            gap_q    <= gap_d;
            valid_q  <= valid_d;
            phase_q  <= phase_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            stage_q  <= stage_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign phase     = phase_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign tw_idx    = tw_q;
    assign stage     = stage_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen (N=16, STAGE_GAP=2) against an
// arithmetic reference of the load and butterfly address streams.
module tb_fft_addr_gen;

    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int GAPC  = 2;
    localparam int IW    = 15;

    logic       clk = 1'b0;
    logic       reset, start, bitrev_en, out_ready;
    logic       out_valid, phase, last, busy, done;
    logic [3:0] addr_a, addr_b;
    logic [2:0] tw_idx;
    logic [1:0] stage;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] got_q[$];
    int            gaps_q[$];
    int            n_xfer;
    int            n_done;

    fft_addr_gen #(.N(N), .STAGE_GAP(GAPC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bitrev_en (bitrev_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .phase     (phase),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .tw_idx    (tw_idx),
        .stage     (stage),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Item layout: {phase, addr_a[3:0], addr_b[3:0], tw[2:0], stage[1:0], last}
    function automatic logic [IW-1:0] pack_item(input bit ph, input int a, input int b,
                                                input int tw, input int st, input bit lst);
        return {ph, 4'(a), 4'(b), 3'(tw), 2'(st), lst};
    endfunction

    function automatic logic [IW-1:0] obs_item();
        return {phase, addr_a, addr_b, tw_idx, stage, last};
    endfunction

    function automatic int ref_bitrev(input int k);
        int v, r;
        v = k;
        r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic build_expected(input bit bitrev);
        int p, lo, hi, a;
        exp_q.delete();
        if (bitrev) begin
            for (int k = 0; k < N; k++)
                exp_q.push_back(pack_item(1'b0, ref_bitrev(k), 0, 0, 0, k == N - 1));
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < N / 2; k++) begin
                p  = 2 ** s;
                lo = k % p;
                hi = k / p;
                a  = hi * 2 * p + lo;
                exp_q.push_back(pack_item(1'b1, a, a + p, lo * (2 ** (LOG2N - 1 - s)), s,
                                          k == N / 2 - 1));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready with one 3-cycle stall mid stage 1.
    // Returns at the negedge where done is seen.
    task automatic run_transform(input bit bitrev, input int mode);
        int            cyc, last_x, idle_run, stall_left;
        bit            prev_stall, seen_done, stalled_once;
        logic [IW-1:0] prev_item, cur, e;
        build_expected(bitrev);
        got_q.delete();
        gaps_q.delete();
        n_xfer = 0;
        n_done = 0;
        @(negedge clk);
        start     = 1'b1;
        bitrev_en = bitrev;
        out_ready = 1'b1;
        @(negedge clk);
        last_x = -1; idle_run = 0; stall_left = 0;
        prev_stall = 1'b0; seen_done = 1'b0; stalled_once = 1'b0;
        prev_item = '0;
        for (cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
            start     = 1'b0;
            bitrev_en = 1'($urandom_range(0, 1));
            if (mode == 2 && !stalled_once && n_xfer == 28) begin
                stall_left   = 3;
                stalled_once = 1'b1;
            end
            if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
            cur = obs_item();
            if (prev_stall) begin
                checks++;
                if (cur !== prev_item || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_stable: got=%h valid=%b exp=%h valid=1", cur, out_valid, prev_item);
                end
            end
            if (done) begin
                n_done++;
                seen_done = 1'b1;
                checks++;
                if (last_x != cyc - 1 || exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL done_timing: last_xfer_cycle=%0d done_cycle=%0d remaining=%0d exp remaining=0",
                             last_x, cyc, exp_q.size());
                end
            end else if (out_valid) begin
                if (idle_run > 0) gaps_q.push_back(idle_run);
                idle_run = 0;
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_item: got=%h exp=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            failures++;
                            $display("FAIL item_%0d: got=%h exp=%h", n_xfer, cur, e);
                        end
                    end
                    got_q.push_back(cur);
                    n_xfer++;
                    last_x = cyc;
                end
            end else if (last_x >= 0) begin
                idle_run++;
            end
            prev_stall = out_valid && !out_ready;
            prev_item  = cur;
            if (busy && !done && $urandom_range(0, 19) == 0) begin
                start     = 1'b1;
                bitrev_en = 1'($urandom_range(0, 1));
            end
            if (!seen_done) @(negedge clk);
        end
        start = 1'b0;
        if (!seen_done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within budget, xfers=%0d", n_xfer);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bitrev_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, obs_item(), busy, done, state_dbg} !== '0) begin
            failures++;
            $display("FAIL reset_init: got valid=%b item=%h busy=%b done=%b state=%0d exp all 0",
                     out_valid, obs_item(), busy, done, state_dbg);
        end
        reset = 1'b0;
        start = 1'b1; bitrev_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({out_valid, obs_item(), busy, done, state_dbg} !== '0) begin
                failures++;
                $display("FAIL reset_mid_load: got valid=%b item=%h busy=%b done=%b exp all 0",
                         out_valid, obs_item(), busy, done);
            end
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: got done=%b busy=%b valid=%b exp 0 0 0", done, busy, out_valid);
            end
        end
    endtask

    task automatic test_load();
        int exp_a[6];
        exp_a = '{0, 8, 4, 12, 2, 10};
        run_transform(1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_q[i][13:10] !== 4'(exp_a[i]) || got_q[i][14] !== 1'b0) begin
                failures++;
                $display("FAIL load_addr_%0d: got=%0d phase=%b exp=%0d phase=0", i, got_q[i][13:10], got_q[i][14], exp_a[i]);
            end
        end
        checks++;
        if (got_q[15][13:10] !== 4'd15 || got_q[15][0] !== 1'b1) begin
            failures++;
            $display("FAIL load_last: got a=%0d last=%b exp a=15 last=1", got_q[15][13:10], got_q[15][0]);
        end
        checks++;
        if (gaps_q.size() != 4 || gaps_q[0] != GAPC || gaps_q[1] != GAPC || gaps_q[2] != GAPC || gaps_q[3] != GAPC) begin
            failures++;
            $display("FAIL load_gaps: got count=%0d first=%0d exp count=4 each=%0d", gaps_q.size(), gaps_q[0], GAPC);
        end
        checks++;
        if (n_xfer != 48) begin
            failures++;
            $display("FAIL load_total: got=%0d exp=48", n_xfer);
        end
    endtask

    task automatic test_bfly_points();
        int idx[4], ea[4], eb[4], et[4];
        idx = '{0, 9, 19, 29};
        ea  = '{0, 1, 3, 5};
        eb  = '{1, 3, 7, 13};
        et  = '{0, 4, 6, 5};
        run_transform(1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[idx[i]][13:3] !== {4'(ea[i]), 4'(eb[i]), 3'(et[i])}) begin
                failures++;
                $display("FAIL bfly_point_s%0d: got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d", i,
                         got_q[idx[i]][13:10], got_q[idx[i]][9:6], got_q[idx[i]][5:3], ea[i], eb[i], et[i]);
            end
        end
        checks++;
        if (n_xfer != 32 || gaps_q.size() != 3 || gaps_q[0] != GAPC || gaps_q[2] != GAPC) begin
            failures++;
            $display("FAIL bfly_only_totals: got xfers=%0d gaps=%0d exp xfers=32 gaps=3", n_xfer, gaps_q.size());
        end
    endtask

    task automatic test_backpressure();
        run_transform(1'b1, 2);
        checks++;
        if (n_xfer != 48 || n_done != 1) begin
            failures++;
            $display("FAIL backpressure_total: got xfers=%0d done=%0d exp 48 1", n_xfer, n_done);
        end
    endtask

    task automatic test_random();
        bit b;
        for (int t = 0; t < 3; t++) begin
            b = 1'($urandom_range(0, 1));
            run_transform(b, 1);
            checks++;
            if (n_xfer != (b ? 48 : 32)) begin
                failures++;
                $display("FAIL random_total_%0d: got=%0d exp=%0d", t, n_xfer, b ? 48 : 32);
            end
        end
    endtask

    task automatic test_done_restart();
        run_transform(1'b0, 0);
        checks++;
        if (got_q[31] !== pack_item(1'b1, 7, 15, 7, 3, 1'b1)) begin
            failures++;
            $display("FAIL final_item: got=%h exp=%h", got_q[31], pack_item(1'b1, 7, 15, 7, 3, 1'b1));
        end
        start = 1'b1; bitrev_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; bitrev_en = 1'b0;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1 || obs_item() !== pack_item(1'b0, 0, 0, 0, 0, 1'b0)) begin
            failures++;
            $display("FAIL restart_in_done: got done=%b valid=%b busy=%b item=%h exp 0 1 1 %h",
                     done, out_valid, busy, obs_item(), pack_item(1'b0, 0, 0, 0, 0, 1'b0));
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs_item() !== pack_item(1'b0, 8, 0, 0, 0, 1'b0) || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL start_while_busy: got=%h valid=%b exp=%h valid=1", obs_item(), out_valid,
                     pack_item(1'b0, 8, 0, 0, 0, 1'b0));
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        bit hit;
        int n;
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1; bitrev_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 200 && !hit; n++) begin
            if (out_valid && stage == 2'd2) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reach_stage2: got no stage 2 item within 200 cycles exp one");
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({out_valid, obs_item(), busy, done} !== '0) begin
                failures++;
                $display("FAIL reset_stage2: got valid=%b item=%h busy=%b done=%b exp all 0",
                         out_valid, obs_item(), busy, done);
            end
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL no_done_after_abort: got done=%b busy=%b exp 0 0", done, busy);
            end
        end
        run_transform(1'b0, 0);
        checks++;
        if (got_q[0] !== pack_item(1'b1, 0, 1, 0, 0, 1'b0) || n_xfer != 32) begin
            failures++;
            $display("FAIL restart_after_abort: got first=%h xfers=%0d exp first=%h xfers=32",
                     got_q[0], n_xfer, pack_item(1'b1, 0, 1, 0, 0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bfly_points();
        test_backpressure();
        test_random();
        test_done_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_addr_gen.md
Name: fft_addr_gen

Overview:
- Sequential address sequencer for the in-place radix-2 DIT FFT memory.
- Issues two kinds of address stream per transform:
  - an optional bit-reversed load stream, N sample addresses;
  - a butterfly stream, N/2 operand pairs plus a twiddle index for every stage.
- Output uses a valid/ready handshake towards the butterfly datapath.
- Inserts a programmable bubble between stages so the pipeline drains before the next stage reads.

Parameters:
- N, 16, FFT points; power of two, minimum 4.
- LOG2N, $clog2(N), address width; derived, do not override.
- STAGE_GAP, 2, idle cycles between stages, 0..15; 0 means no gap.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- bitrev_en  in  1  sampled with start; 1 runs the LOAD phase first.
- out_ready  in  1  downstream accepts the current address item.
- out_valid  out  1  address item is valid.
- phase  out  1  0 = load item, 1 = butterfly item.
- addr_a  out  LOG2N  load address, or butterfly top operand.
- addr_b  out  LOG2N  butterfly bottom operand; 0 during load.
- tw_idx  out  LOG2N-1  twiddle index into an N/2-entry ROM; 0 during load.
- stage  out  max(1,$clog2(LOG2N))  current stage s; 0 during load.
- last  out  1  current item is the last of its phase or stage.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the final butterfly item is accepted.

Behaviour:
- Reset (synchronous, active-high; mid-operation included):
  - next edge forces IDLE and clears every counter;
  - all outputs are 0;
  - any transform in progress is abandoned with no done pulse.
- States: IDLE, LOAD, RUN, GAP.
- Transitions:
  - IDLE + start: to LOAD if bitrev_en=1, else to RUN; s=0, k=0.
  - LOAD: k runs 0..N-1. On accepting k=N-1, go to GAP, or to RUN if STAGE_GAP=0.
  - RUN: k runs 0..N/2-1. On accepting k=N/2-1:
    - if s<LOG2N-1: go to GAP (or stay in RUN if STAGE_GAP=0), with s+1 and k=0;
    - else: go to IDLE and assert done for that one cycle.
  - GAP: out_valid=0 for exactly STAGE_GAP cycles, then RUN.
- Handshake:
  - A transfer occurs when out_valid and out_ready are both high; k advances only on a transfer.
  - With out_valid=1 and out_ready=0, every output holds stable.
  - out_valid may not drop until the item is accepted.
- Latency and registering:
  - All outputs are registered.
  - The first item is valid on the cycle after start is sampled.
  - Back-to-back items are produced every cycle while out_ready=1.
- LOAD item:
  - addr_a = bit_reverse(k) over LOG2N bits;
  - last = (k==N-1).
- RUN item:
  - lo = k mod 2^s, hi = k >> s;
  - addr_a = (hi << (s+1)) | lo;
  - addr_b = addr_a | (1<<s);
  - tw_idx = lo << (LOG2N-1-s);
  - last = (k==N/2-1).
- Corner cases:
  - start while busy is ignored.
  - start in the done cycle is accepted, because the block is already in IDLE.
  - A transform with bitrev_en=0 contains no LOAD phase and no pre-RUN gap.
- Totals per transform:
  - butterfly transfers = LOG2N*N/2;
  - load transfers = N, when enabled.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum;
  - function bit_reverse(value, width);
  - function insert_zero(k, s), which returns addr_a;
  - the localparam derivations for LOG2N and the stage width.
- One sub-module, fft_bfly_index: purely combinational, mapping (k, s) to (addr_a, addr_b, tw_idx).
- The top-level block holds the FSM, counters, handshake and output registers.

Test Plan:
- Reset and idle: assert reset for 2 cycles while outputs are toggling -> every output reads 0, busy=0, and no done pulse appears.
- Load phase: N=16, bitrev_en=1, out_ready tied to 1 -> addr_a sequence begins 0,8,4,12,2,10 and the 16th item is 15 with last=1; then exactly 2 cycles with out_valid=0.
- Butterfly addressing with N=16:
  - s=0, k=0 gives a=0, b=1, tw=0;
  - s=1, k=1 gives a=1, b=3, tw=4;
  - s=2, k=3 gives a=3, b=7, tw=6;
  - s=3, k=5 gives a=5, b=13, tw=5.
- Backpressure: drop out_ready for 3 cycles in the middle of stage 1 -> outputs hold stable, no item is skipped or duplicated, and the total transfer count is 32 butterflies plus 16 loads.
- Completion and restart: done pulses exactly once, the cycle after the final item (s=3, k=7, a=7, b=15, tw=7) is accepted. Raise start in the done cycle -> a new transform starts, and start raised while busy is ignored.
- Reset mid-operation: assert reset during stage 2 -> the block returns to IDLE with no done pulse, and a following start begins again at s=0, k=0.
